// File: rtl/aoi222_char_sequencer.sv
// aoi222_char_sequencer: drives exhaustive/LFSR patterns into an AOI222 cell and checks/counts its QN response.
module aoi222_char_sequencer #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             mode,
    input  logic             qn_dut,
    output logic             in1,
    output logic             in2,
    output logic             in3,
    output logic             in4,
    output logic             in5,
    output logic             in6,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] tog_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam logic [3:0] SET = 4'(SETTLE);
    state_t     state;
    logic [5:0] pat;
    logic       mode_q;
    logic [3:0] wait_cnt;
    logic       prev_qn;
    logic       have_prev;
    logic       golden;
    logic       mism;
    logic       last;
    logic [5:0] nxt;
    assign {in6, in5, in4, in3, in2, in1} = pat;
    assign golden = ~((pat[0] & pat[1]) | (pat[2] & pat[3]) | (pat[4] & pat[5]));
    // case-inequality so an X/Z on the cell output is scored as a mismatch
    assign mism = qn_dut !== golden;
    assign nxt  = mode_q ? {pat[4:0], pat[5] ^ pat[4]} : pat + 6'd1;
    assign last = mode_q ? (pat == 6'b100000) : (pat == 6'd63);
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            pat       <= '0;
            mode_q    <= 1'b0;
            wait_cnt  <= '0;
            prev_qn   <= 1'b0;
            have_prev <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= '0;
            tog_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_q    <= mode;
                    pat       <= mode ? 6'd1 : 6'd0;
                    err_cnt   <= '0;
                    tog_cnt   <= '0;
                    fail      <= 1'b0;
                    have_prev <= 1'b0;
                    wait_cnt  <= SET;
                    busy      <= 1'b1;
                    state     <= RUN;
                end
                RUN: if (wait_cnt == 4'd1) begin
                    if (mism) begin
                        fail <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    end
                    if (have_prev && (qn_dut !== prev_qn) && tog_cnt != '1) tog_cnt <= tog_cnt + 1'b1;
                    prev_qn   <= qn_dut;
                    have_prev <= 1'b1;
                    if (last) begin
                        pat   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        pat      <= nxt;
                        wait_cnt <= SET;
                    end
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aoi222_char_sequencer.sv
// tb_aoi222_char_sequencer: randomized self-checking bench; two instances cover SETTLE=2/CNT_W=8 and SETTLE=1/CNT_W=4.
module tb_aoi222_char_sequencer;
    logic clk = 0, rstb = 1, start_a = 0, start_b = 0, mode = 0;
    int sel = 0;
    logic [63:0] flip = '0;
    logic [5:0] a_bus, b_bus;
    logic qn_a, qn_b, a_busy, a_done, a_fail, b_busy, b_done, b_fail;
    logic [7:0] a_err, a_tog;
    logic [3:0] b_err, b_tog;
    logic ga, gb;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    // cell model: 0 ideal, 1 stuck-0, 2 stuck-1, 3 ideal with random per-pattern flips
    assign ga = ~((a_bus[0] & a_bus[1]) | (a_bus[2] & a_bus[3]) | (a_bus[4] & a_bus[5]));
    assign gb = ~((b_bus[0] & b_bus[1]) | (b_bus[2] & b_bus[3]) | (b_bus[4] & b_bus[5]));
    assign qn_a = sel == 1 ? 1'b0 : sel == 2 ? 1'b1 : sel == 3 ? ga ^ flip[a_bus] : ga;
    assign qn_b = sel == 1 ? 1'b0 : sel == 2 ? 1'b1 : sel == 3 ? gb ^ flip[b_bus] : gb;
    aoi222_char_sequencer #(.SETTLE(2), .CNT_W(8)) u_a (
        .clk(clk), .rstb(rstb), .start(start_a), .mode(mode), .qn_dut(qn_a),
        .in1(a_bus[0]), .in2(a_bus[1]), .in3(a_bus[2]), .in4(a_bus[3]), .in5(a_bus[4]), .in6(a_bus[5]),
        .busy(a_busy), .done(a_done), .fail(a_fail), .err_cnt(a_err), .tog_cnt(a_tog));
    aoi222_char_sequencer #(.SETTLE(1), .CNT_W(4)) u_b (
        .clk(clk), .rstb(rstb), .start(start_b), .mode(mode), .qn_dut(qn_b),
        .in1(b_bus[0]), .in2(b_bus[1]), .in3(b_bus[2]), .in4(b_bus[3]), .in5(b_bus[4]), .in6(b_bus[5]),
        .busy(b_busy), .done(b_done), .fail(b_fail), .err_cnt(b_err), .tog_cnt(b_tog));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic run(input bit b, input bit m, input int qsel, input bit hold, input bit poke);
        int s, mx, n, e_err, e_tog, dups;
        logic [5:0] seq[$];
        logic q[$];
        bit seen[64];
        logic [5:0] p;
        s = b ? 1 : 2;
        mx = b ? 15 : 255;
        e_err = 0;
        e_tog = 0;
        dups = 0;
        sel = qsel;
        if (qsel == 3) flip = {$urandom, $urandom};
        // the run visits every pattern of one full period of the generator
        p = m ? 6'd1 : 6'd0;
        do begin
            seq.push_back(p);
            p = m ? {p[4:0], p[5] ^ p[4]} : p + 6'd1;
        end while (p != seq[0]);
        n = seq.size();
        foreach (seq[k]) begin
            logic g, qv;
            g = ~((seq[k][0] & seq[k][1]) | (seq[k][2] & seq[k][3]) | (seq[k][4] & seq[k][5]));
            qv = qsel == 1 ? 1'b0 : qsel == 2 ? 1'b1 : qsel == 3 ? g ^ flip[seq[k]] : g;
            q.push_back(qv);
            if (qv != g && e_err < mx) e_err++;
            if (k > 0 && qv != q[k-1] && e_tog < mx) e_tog++;
        end
        mode = m;
        @(negedge clk);
        if (b) start_b = 1; else start_a = 1;
        @(posedge clk);
        #1;
        if (!hold) begin start_a = 0; start_b = 0; end
        mode = $urandom_range(0, 1);
        for (int e = 0; e < n * s; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            chk("bus", b ? b_bus : a_bus, seq[e / s]);
            chk("busy", b ? b_busy : a_busy, 1);
            chk("done_early", b ? b_done : a_done, 0);
            if (e % s == 0) begin
                if (seen[b ? b_bus : a_bus]) dups++;
                seen[b ? b_bus : a_bus] = 1;
            end
            if (poke && e == 5) begin if (b) start_b = 1; else start_a = 1; end
            if (poke && e == 6 && !hold) begin start_a = 0; start_b = 0; end
        end
        @(posedge clk);
        #1;
        chk("done", b ? b_done : a_done, 1);
        chk("busy_end", b ? b_busy : a_busy, 0);
        chk("bus_end", b ? b_bus : a_bus, 0);
        chk("err_cnt", b ? b_err : a_err, e_err);
        chk("tog_cnt", b ? b_tog : a_tog, e_tog);
        chk("fail", b ? b_fail : a_fail, e_err > 0);
        chk("dups", dups, 0);
        @(posedge clk);
        #1;
        chk("done_pulse", b ? b_done : a_done, 0);
        chk("err_hold", b ? b_err : a_err, e_err);
    endtask
    initial begin
        bit done_seen;
        #2 rstb = 0;
        #1;
        chk("rst_bus", {a_bus, b_bus}, 0);
        chk("rst_flags", {a_busy, a_done, a_fail, b_busy, b_done, b_fail}, 0);
        chk("rst_cnt", {a_err, a_tog, b_err, b_tog}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstb = 1;
        run(0, 0, 0, 0, 0);
        run(0, 0, 1, 0, 0);
        run(0, 0, 2, 0, 0);
        run(1, 1, 0, 0, 0);
        run(0, 1, 0, 0, 0);
        run(1, 0, 2, 0, 0);
        run(1, 0, 3, 0, 0);
        // abort during pattern 10 of an exhaustive run with a stuck-1 cell
        sel = 2;
        mode = 0;
        @(negedge clk) start_a = 1;
        @(posedge clk);
        #1 start_a = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("pre_rst_bus", a_bus, 10);
        chk("pre_rst_err", a_err, 2);
        #2 rstb = 0;
        #1;
        chk("abort_bus", a_bus, 0);
        chk("abort_flags", {a_busy, a_done, a_fail}, 0);
        chk("abort_cnt", {a_err, a_tog}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rstb = 1;
        done_seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (a_done || a_busy) done_seen = 1;
        end
        chk("no_done_after_abort", done_seen, 0);
        run(0, 0, 0, 0, 0);
        run(0, 0, 3, 0, 1);
        run(1, 1, 3, 0, 1);
        start_a = 1;
        run(0, 0, 3, 1, 0);
        run(0, 1, 3, 1, 0);
        run(0, 0, 2, 1, 0);
        start_a = 0;
        #2 rstb = 0;
        #3 rstb = 1;
        for (int r = 0; r < 3; r++) run(r[0], 1'($urandom_range(0, 1)), 3, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aoi222_char_sequencer.md
# aoi222_char_sequencer

Self-checking stimulus/capture stage for characterising one AOI222 cell instance, used in power and functional runs.
- Upstream: drives the cell's six inputs IN1..IN6 with an exhaustive or LFSR pattern sequence.
- Downstream: samples the cell's QN output after a settle window and checks it against the golden function QN = ~((IN1&IN2)|(IN3&IN4)|(IN5&IN6)).
- Accumulates mismatch and QN-toggle counts for activity-based power correlation.

## Interface
- SETTLE, 2, cycles from pattern apply to QN sample; legal range 1..15.
- CNT_W, 8, width of ERR_CNT and TOG_CNT.
- CLK  in  1  sole clock, rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- START  in  1  run request, sampled only in IDLE.
- MODE  in  1  0 = exhaustive (64 patterns), 1 = LFSR (63 patterns); sampled with START.
- QN_DUT  in  1  output of the cell under test.
- IN1..IN6  out  1 each  registered stimulus to the cell under test; pattern bit i drives IN(i+1).
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  one-cycle pulse at end of run.
- FAIL  out  1  sticky; set on the first mismatch of a run.
- ERR_CNT  out  CNT_W  mismatch count, saturating.
- TOG_CNT  out  CNT_W  QN sample-to-sample toggle count, saturating.

## Operation
- **States:** IDLE, RUN, FIN.
- **Reset (RSTB low, asynchronous):** state = IDLE; IN1..IN6 = 0; BUSY, DONE, FAIL = 0; ERR_CNT = TOG_CNT = 0; internal wait counter, previous-QN flag and pattern count cleared.
- **IDLE:** IN1..IN6 held at 0. START=1 at an edge causes, at that same edge:
  - latch MODE;
  - load the first pattern: 6'd0 in exhaustive mode, 6'b000001 in LFSR mode;
  - clear ERR_CNT, TOG_CNT and FAIL;
  - load the wait counter with SETTLE;
  - BUSY=1; state moves to RUN.
- **RUN:** the wait counter decrements each cycle. At the edge where it expires (SETTLE edges after the pattern was applied), perform a sample. At that same edge:
  - compare QN_DUT to the golden value computed from the current pattern register; on inequality, increment ERR_CNT and set FAIL;
  - if a previous sample exists and QN_DUT differs from it, increment TOG_CNT (the first sample of a run never counts as a toggle);
  - store QN_DUT as the previous sample;
  - if this was the last pattern, go to FIN with IN1..IN6 = 0; otherwise load the next pattern and reload the wait counter with SETTLE.
- **Next pattern:**
  - Exhaustive: +1; the last pattern is 63.
  - LFSR: shift left, with new bit0 = bit5 ^ bit4 (x^6+x^5+1, maximal); the last pattern is the one whose successor would be 6'b000001. The all-zero pattern is never produced.
- **FIN:** DONE=1 and BUSY=0 for exactly one cycle, then IDLE. Counters and FAIL hold their values until the next START or reset.
- **Counter saturation:** ERR_CNT and TOG_CNT stop at 2^CNT_W-1 and do not wrap.
- **Simultaneous events:**
  - START while in RUN or FIN is ignored.
  - START held high continuously starts a new run on the first IDLE cycle after FIN.
  - Reset mid-run aborts immediately; no DONE is produced.
- **Unknowns:** an X or Z on QN_DUT at a sample edge counts as a mismatch. The implementation uses case-inequality against the golden value in simulation.

## Timing
- Edge 0 is the edge that samples START=1. The first pattern is visible on IN1..IN6 after edge 0.
- Sample k (k = 1..N) occurs at edge k·SETTLE; pattern k+1 appears at that same edge.
- N = 64 (exhaustive) or 63 (LFSR).
- Last sample is at edge N·SETTLE. DONE is high during the cycle after that edge; BUSY falls at the same edge.
- Each pattern is stable on IN1..IN6 for exactly SETTLE cycles. There are no glitch cycles between consecutive patterns.
- All outputs are registered; no combinational path runs from QN_DUT or START to any output.

## Test plan
- Ideal AOI222 model, MODE=0, SETTLE=2: IN bus sequences 0..63; DONE pulses after edge 128; ERR_CNT=0, FAIL=0, TOG_CNT=17.
- QN_DUT stuck at 0, MODE=0: ERR_CNT=27, FAIL=1, TOG_CNT=0. QN_DUT stuck at 1: ERR_CNT=37, TOG_CNT=0.
- Ideal model, MODE=1, SETTLE=1: 63 distinct nonzero patterns, starting 000001, 000010, 000100; DONE after edge 63; ERR_CNT=0; the pattern never repeats before DONE.
- CNT_W=4 with QN_DUT stuck at 1, MODE=0: ERR_CNT saturates at 15, FAIL=1, no wrap.
- RSTB pulsed low during pattern 10 of an exhaustive run: all outputs go to 0 immediately and no DONE is produced. A subsequent START runs cleanly with the counts of the first scenario.
- START pulsed during RUN: no effect on sequence or counts. START held high: back-to-back runs, each with a single DONE pulse and counters cleared at each start.
